// File: rtl/mem_stream_sequencer_if.sv
// ============================================================================
// Module   : mem_stream_sequencer_if
// Brief    : Memory-unit bus between the stream sequencer (master) and memory (slave).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_stream_sequencer_if #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int NUM_VECTORS    = 5,
  parameter int DATA_WIDTH     = 320
);
  logic                      mem_read_enable;
  logic                      mem_write_enable;
  logic [MEM_ADDR_WIDTH-1:0] mem_address;
  logic [NUM_VECTORS-1:0]    mem_vector_length;
  logic [DATA_WIDTH-1:0]     mem_write_data;
  logic [DATA_WIDTH-1:0]     mem_read_data;
  logic                      mem_ready;

  modport master (
    output mem_read_enable, mem_write_enable, mem_address, mem_vector_length, mem_write_data,
    input  mem_read_data, mem_ready
  );

  modport slave (
    input  mem_read_enable, mem_write_enable, mem_address, mem_vector_length, mem_write_data,
    output mem_read_data, mem_ready
  );
endinterface

`default_nettype wire

// File: rtl/mem_stream_sequencer.sv
// ============================================================================
// Module   : mem_stream_sequencer
// Brief    : Vector load/store initiator, one outstanding memory access at a time.
//            Optional WAIT-state watchdog enabled by defining MEM_SEQ_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_stream_sequencer #(
  parameter int MEM_ADDR_WIDTH      = 10,
  parameter int NUM_VECTORS         = 5,
  parameter int MIN_VEC_LENGTH      = 16,
  parameter int NUM_TILES_PER_SLICE = 20,
  parameter int CNT_WIDTH           = 8,
  parameter int STREAM_ID_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES      = 255
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          cmd_valid,
  output logic                                          cmd_ready,
  input  logic                                          cmd_write,
  input  logic [MEM_ADDR_WIDTH-1:0]                     cmd_addr,
  input  logic [NUM_VECTORS-1:0]                        cmd_vec_len,
  input  logic [CNT_WIDTH-1:0]                          cmd_count,
  input  logic [STREAM_ID_WIDTH-1:0]                    cmd_stream_id,
  input  logic                                          wr_valid,
  output logic                                          wr_ready,
  input  logic [MIN_VEC_LENGTH*NUM_TILES_PER_SLICE-1:0] wr_data,
  output logic                                          rd_valid,
  input  logic                                          rd_ready,
  output logic [MIN_VEC_LENGTH*NUM_TILES_PER_SLICE-1:0] rd_data,
  output logic [STREAM_ID_WIDTH-1:0]                    rd_stream_id,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          err_timeout,
  mem_stream_sequencer_if.master                        mem
);

  localparam int                     c_DATA_W  = MIN_VEC_LENGTH * NUM_TILES_PER_SLICE;
  localparam logic [NUM_VECTORS-1:0] c_MAX_LEN = NUM_VECTORS'(NUM_TILES_PER_SLICE);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_WDATA = 3'd1;
  localparam logic [2:0] c_ISSUE = 3'd2;
  localparam logic [2:0] c_WAIT  = 3'd3;
  localparam logic [2:0] c_OUT   = 3'd4;

  logic [2:0]                 r_state;
  logic [2:0]                 w_next_state;
  logic                       r_write;
  logic [MEM_ADDR_WIDTH-1:0]  r_addr;
  logic [NUM_VECTORS-1:0]     r_vec_len;
  logic [CNT_WIDTH-1:0]       r_remaining;
  logic [STREAM_ID_WIDTH-1:0] r_stream_id;
  logic [c_DATA_W-1:0]        r_wr_data;
  logic [c_DATA_W-1:0]        r_rd_data;
  logic                       r_done;
  logic [c_DATA_W-1:0]        w_mask;
  logic [NUM_VECTORS-1:0]     w_cmd_len;
  logic                       w_accept;
  logic                       w_empty;
  logic                       w_last;
  logic                       w_advance;
  logic                       w_timeout;

  assign w_accept  = cmd_valid && (r_state == c_IDLE);
  assign w_empty   = (cmd_count == '0) || (cmd_vec_len == '0);
  assign w_cmd_len = (cmd_vec_len > c_MAX_LEN) ? c_MAX_LEN : cmd_vec_len;
  assign w_last    = (r_remaining == CNT_WIDTH'(1));
  assign w_advance = ((r_state == c_WAIT) && mem.mem_ready && r_write) ||
                     ((r_state == c_OUT) && rd_ready);

  // Element lanes at or beyond the active vector length are forced to zero.
  for (genvar i = 0; i < NUM_TILES_PER_SLICE; i++) begin : g_mask
    assign w_mask[i*MIN_VEC_LENGTH +: MIN_VEC_LENGTH] =
      (NUM_VECTORS'(i) < r_vec_len) ? {MIN_VEC_LENGTH{1'b1}} : {MIN_VEC_LENGTH{1'b0}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_accept && !w_empty) begin
          w_next_state = cmd_write ? c_WDATA : c_ISSUE;
        end
      end
      c_WDATA: begin
        if (wr_valid) begin
          w_next_state = c_ISSUE;
        end
      end
      c_ISSUE: begin
        w_next_state = c_WAIT;
      end
      c_WAIT: begin
        if (mem.mem_ready) begin
          if (!r_write) begin
            w_next_state = c_OUT;
          end else begin
            w_next_state = w_last ? c_IDLE : c_WDATA;
          end
        end else if (w_timeout) begin
          w_next_state = c_IDLE;
        end
      end
      c_OUT: begin
        if (rd_ready) begin
          w_next_state = w_last ? c_IDLE : c_ISSUE;
        end
      end
      default: begin
        w_next_state = c_IDLE;
      end
    endcase
  end

  always_comb begin
    cmd_ready            = (r_state == c_IDLE);
    wr_ready             = (r_state == c_WDATA);
    rd_valid             = (r_state == c_OUT);
    busy                 = (r_state != c_IDLE);
    mem.mem_read_enable  = (r_state == c_ISSUE) && !r_write;
    mem.mem_write_enable = (r_state == c_ISSUE) && r_write;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_vec_len   <= '0;
      r_remaining <= '0;
      r_stream_id <= '0;
      r_wr_data   <= '0;
      r_rd_data   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (w_accept && w_empty) || (w_advance && w_last);
      if (w_accept) begin
        r_write     <= cmd_write;
        r_addr      <= cmd_addr;
        r_vec_len   <= w_cmd_len;
        r_remaining <= cmd_count;
        r_stream_id <= cmd_stream_id;
      end
      if ((r_state == c_WDATA) && wr_valid) begin
        r_wr_data <= wr_data & w_mask;
      end
      if ((r_state == c_WAIT) && mem.mem_ready && !r_write) begin
        r_rd_data <= mem.mem_read_data & w_mask;
      end
      // Elements sit at a stride of two words, so each vector spans 2*len addresses.
      if (w_advance) begin
        r_remaining <= r_remaining - CNT_WIDTH'(1);
        r_addr      <= r_addr + MEM_ADDR_WIDTH'({r_vec_len, 1'b0});
      end
    end
  end

`ifdef MEM_SEQ_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_TO_W-1:0] r_wait_cnt;
  logic              r_err_timeout;

  assign w_timeout = (r_state == c_WAIT) && !mem.mem_ready &&
                     (r_wait_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt    <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= w_timeout;
      if (r_state == c_ISSUE) begin
        r_wait_cnt <= '0;
      end else if (r_state == c_WAIT) begin
        r_wait_cnt <= r_wait_cnt + c_TO_W'(1);
      end
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign rd_data               = r_rd_data;
  assign rd_stream_id          = r_stream_id;
  assign done                  = r_done;
  assign mem.mem_address       = r_addr;
  assign mem.mem_vector_length = r_vec_len;
  assign mem.mem_write_data    = r_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_stream_sequencer.sv
// ============================================================================
// Module   : tb_mem_stream_sequencer
// Brief    : Directed bench for mem_stream_sequencer with a two-cycle memory responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_stream_sequencer;

  localparam int c_DW = 320;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid, cmd_ready, cmd_write;
  logic [9:0]       cmd_addr;
  logic [4:0]       cmd_vec_len;
  logic [7:0]       cmd_count;
  logic [4:0]       cmd_stream_id;
  logic             wr_valid, wr_ready;
  logic [c_DW-1:0]  wr_data;
  logic             rd_valid, rd_ready;
  logic [c_DW-1:0]  rd_data;
  logic [4:0]       rd_stream_id;
  logic             busy, done, err_timeout;

  int n_chk = 0;
  int n_err = 0;
  int n_rd  = 0;
  int n_wr  = 0;
  int n_both = 0;
  logic ready_en;
  logic pend;

  mem_stream_sequencer_if #(.MEM_ADDR_WIDTH(10), .NUM_VECTORS(5), .DATA_WIDTH(c_DW)) mem_if ();

  mem_stream_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_vec_len(cmd_vec_len), .cmd_count(cmd_count),
    .cmd_stream_id(cmd_stream_id),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_stream_id(rd_stream_id),
    .busy(busy), .done(done), .err_timeout(err_timeout),
    .mem(mem_if.master)
  );

  always #5 clk = ~clk;

  // Memory responder: registers the strobe, answers with mem_ready one cycle later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend             <= 1'b0;
      mem_if.mem_ready <= 1'b0;
    end else begin
      pend             <= (mem_if.mem_read_enable || mem_if.mem_write_enable) && ready_en;
      mem_if.mem_ready <= pend;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (mem_if.mem_read_enable)  n_rd++;
      if (mem_if.mem_write_enable) n_wr++;
      if (mem_if.mem_read_enable && mem_if.mem_write_enable) n_both++;
    end
  end

  task automatic check_value(input string tag, input logic [c_DW-1:0] got,
                             input logic [c_DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue_cmd(input logic w, input logic [9:0] a, input logic [4:0] l,
                           input logic [7:0] c, input logic [4:0] s);
    cmd_write = w; cmd_addr = a; cmd_vec_len = l; cmd_count = c; cmd_stream_id = s;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // sel: 0 = rd_valid, 1 = wr_ready, 2 = done, 3 = err_timeout
  task automatic wait_sig(input int sel, input int max_cycles, input string tag,
                          output int cycles);
    bit hit = 1'b0;
    cycles = 0;
    for (int k = 0; k < max_cycles; k++) begin
      if ((sel == 0 && rd_valid) || (sel == 1 && wr_ready) ||
          (sel == 2 && done) || (sel == 3 && err_timeout)) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
    check_value(tag, c_DW'(hit), c_DW'(1));
  endtask

  logic [c_DW-1:0] pat, exp_v, vec_a, vec_b, snap;
  int              cyc, nrd0, nacc0;
  bit              stable;

  initial begin
    for (int i = 0; i < 20; i++) begin
      pat[16*i +: 16]   = 16'(i + 1);
      vec_a[16*i +: 16] = 16'hA000 + 16'(i);
      vec_b[16*i +: 16] = 16'hB000 + 16'(i);
    end
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_vec_len = '0;
    cmd_count = '0; cmd_stream_id = '0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    ready_en = 1'b1; mem_if.mem_read_data = pat;
    tick(2);
    rst_n = 1'b1;
    tick(1);

    check_value("rst_cmd_ready", c_DW'(cmd_ready), c_DW'(1));
    check_value("rst_busy", c_DW'({busy, rd_valid, wr_ready, done, err_timeout}), '0);
    check_value("rst_enables", c_DW'({mem_if.mem_read_enable, mem_if.mem_write_enable}), '0);
    check_value("rst_rd_data", rd_data, '0);
    check_value("rst_wr_data", mem_if.mem_write_data, '0);

    // Single read, latency and masking.
    issue_cmd(1'b0, 10'h010, 5'd4, 8'd1, 5'h0A);
    check_value("rd1_strobe", c_DW'({mem_if.mem_read_enable, mem_if.mem_write_enable}), c_DW'(2'b10));
    check_value("rd1_addr", c_DW'(mem_if.mem_address), c_DW'(10'h010));
    check_value("rd1_len", c_DW'(mem_if.mem_vector_length), c_DW'(4));
    tick(1);
    check_value("rd1_strobe_once", c_DW'(mem_if.mem_read_enable), '0);
    tick(1);
    check_value("rd1_valid_e2", c_DW'(rd_valid), '0);
    tick(1);
    check_value("rd1_valid_e3", c_DW'(rd_valid), c_DW'(1));
    exp_v = '0;
    for (int i = 0; i < 4; i++) exp_v[16*i +: 16] = 16'(i + 1);
    check_value("rd1_data", rd_data, exp_v);
    check_value("rd1_sid", c_DW'(rd_stream_id), c_DW'(5'h0A));
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    check_value("rd1_done", c_DW'({done, cmd_ready, rd_valid}), c_DW'(3'b110));
    tick(1);
    check_value("rd1_done_pulse", c_DW'(done), '0);
    check_value("rd1_nstrobe", c_DW'(n_rd), c_DW'(1));

    // Two-vector write with address wrap.
    issue_cmd(1'b1, 10'h3FC, 5'd3, 8'd2, 5'h01);
    check_value("wr_ready0", c_DW'(wr_ready), c_DW'(1));
    wr_data = vec_a; wr_valid = 1'b1;
    tick(1);
    wr_valid = 1'b0;
    exp_v = '0;
    for (int i = 0; i < 3; i++) exp_v[16*i +: 16] = 16'hA000 + 16'(i);
    check_value("wr1_strobe", c_DW'({mem_if.mem_read_enable, mem_if.mem_write_enable}), c_DW'(2'b01));
    check_value("wr1_addr", c_DW'(mem_if.mem_address), c_DW'(10'h3FC));
    check_value("wr1_data", mem_if.mem_write_data, exp_v);
    tick(2);
    check_value("wr_ready_w2", c_DW'(wr_ready), '0);
    tick(1);
    check_value("wr_ready_w3", c_DW'(wr_ready), c_DW'(1));
    wr_data = vec_b; wr_valid = 1'b1;
    tick(1);
    wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) exp_v[16*i +: 16] = 16'hB000 + 16'(i);
    check_value("wr2_addr_wrap", c_DW'(mem_if.mem_address), c_DW'(10'h002));
    check_value("wr2_data", mem_if.mem_write_data, exp_v);
    tick(2);
    check_value("wr2_done_early", c_DW'(done), '0);
    tick(1);
    check_value("wr2_done", c_DW'(done), c_DW'(1));
    check_value("wr_nstrobe", c_DW'(n_wr), c_DW'(2));

    // Read back-pressure: output held, no new strobe until accept.
    issue_cmd(1'b0, 10'h100, 5'd2, 8'd2, 5'h07);
    wait_sig(0, 10, "bp_valid1", cyc);
    snap = rd_data; nrd0 = n_rd; stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (rd_data !== snap || !rd_valid) stable = 1'b0;
    end
    check_value("bp_stable", c_DW'(stable), c_DW'(1));
    check_value("bp_no_strobe", c_DW'(n_rd), c_DW'(nrd0));
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    check_value("bp_strobe2", c_DW'(mem_if.mem_read_enable), c_DW'(1));
    check_value("bp_addr2", c_DW'(mem_if.mem_address), c_DW'(10'h104));
    wait_sig(0, 10, "bp_valid2", cyc);
    exp_v = '0;
    exp_v[15:0] = 16'd1; exp_v[31:16] = 16'd2;
    check_value("bp_data2", rd_data, exp_v);
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    check_value("bp_done", c_DW'(done), c_DW'(1));

    // Empty commands and length clamp.
    nacc0 = n_rd + n_wr;
    issue_cmd(1'b0, 10'h040, 5'd4, 8'd0, 5'h00);
    check_value("cnt0_done", c_DW'({done, busy}), c_DW'(2'b10));
    issue_cmd(1'b1, 10'h040, 5'd0, 8'd3, 5'h00);
    check_value("len0_done", c_DW'({done, busy}), c_DW'(2'b10));
    tick(3);
    check_value("empty_no_strobe", c_DW'(n_rd + n_wr), c_DW'(nacc0));
    issue_cmd(1'b0, 10'h000, 5'd25, 8'd1, 5'h03);
    check_value("clamp_len", c_DW'(mem_if.mem_vector_length), c_DW'(20));
    wait_sig(0, 10, "clamp_valid", cyc);
    check_value("clamp_data", rd_data, pat);
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    check_value("clamp_done", c_DW'(done), c_DW'(1));

    // Asynchronous reset while waiting on memory.
    ready_en = 1'b0;
    issue_cmd(1'b0, 10'h020, 5'd1, 8'd1, 5'h02);
    tick(1);
    check_value("wait_busy", c_DW'(busy), c_DW'(1));
    #2 rst_n = 1'b0;
    #1;
    check_value("arst_outputs",
                c_DW'({mem_if.mem_read_enable, mem_if.mem_write_enable, busy, rd_valid, done}), '0);
    check_value("arst_cmd_ready", c_DW'(cmd_ready), c_DW'(1));
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check_value("arst_no_done", c_DW'({done, busy}), '0);

`ifdef MEM_SEQ_TIMEOUT_EN
    issue_cmd(1'b0, 10'h030, 5'd2, 8'd1, 5'h04);
    wait_sig(3, 400, "to_pulse", cyc);
    check_value("to_cycles", c_DW'(cyc), c_DW'(256));
    check_value("to_state", c_DW'({done, rd_valid, busy, cmd_ready}), c_DW'(4'b0001));
    tick(1);
    check_value("to_pulse_len", c_DW'({err_timeout, done}), '0);
    check_value("total_rd", c_DW'(n_rd), c_DW'(6));
`else
    check_value("no_timeout_out", c_DW'(err_timeout), '0);
    check_value("total_rd", c_DW'(n_rd), c_DW'(5));
`endif
    ready_en = 1'b1;
    check_value("total_wr", c_DW'(n_wr), c_DW'(2));
    check_value("no_dual_strobe", c_DW'(n_both), '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
